// File: rtl/nrzi_stuff_piso.sv
// nrzi_stuff_piso
// Parallel-in serial-out USB-style line driver. A payload of up to W bits is
// captured on load, then sent one bit per clock as NRZI (a 0 toggles the line,
// a 1 holds it). After STUFF_RUN consecutive payload 1s a stuffed 0 (a toggle)
// is inserted. The packet ends with two SE0 cycles and one J cycle, in which
// done pulses.
//
// Ports
//   clock    : rising-edge clock, one bit period per cycle
//   reset    : synchronous active-high reset
//   load     : start request, accepted only while ready=1
//   D        : payload bits, sampled on accept
//   len      : payload bit count, sampled on accept (clamped to W)
//   ready    : idle, able to accept load
//   dp / dm  : D+ / D- line levels (J = 1/0, K = 0/1, SE0 = 0/0)
//   drive_en : block is driving the bus
//   done     : one-cycle pulse in the final J cycle of a packet
module nrzi_stuff_piso #(
    parameter int W         = 32,
    parameter int MSB_FIRST = 0,
    parameter int STUFF_RUN = 6,
    parameter int LW        = $clog2(W + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [W-1:0]  D,
    input  logic [LW-1:0] len,
    output logic          ready,
    output logic          dp,
    output logic          dm,
    output logic          drive_en,
    output logic          done
);
    localparam int OW = $clog2(STUFF_RUN + 1);

    typedef enum logic [2:0] {IDLE, SEND, STUFF, EOP0, EOP1, EOPJ} state_t;

    state_t        r_state;
    logic [W-1:0]  r_sh;      // remaining payload, next bit at the output end
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_cnt;     // payload bits already emitted
    logic [OW-1:0] r_ones;    // current run of payload 1s
    logic          r_lvl;     // NRZI level currently on the line (1 = J)

    logic [LW-1:0] w_len_c;
    logic [W-1:0]  w_src;
    logic [W-1:0]  w_sh_nxt;
    logic          w_bit;
    logic          w_lvl_nxt;
    logic [OW-1:0] w_ones_nxt;
    logic          w_stuff;
    logic          w_last;
    logic          w_emit;
    logic          w_to_stuff;
    logic          w_to_eop;

    assign w_len_c = (len > LW'(W)) ? LW'(W) : len;

    // In IDLE the first bit comes straight from D; MSB-first payloads are
    // left-aligned so that bit len-1 sits at W-1 and shifts out first.
    assign w_src = (r_state != IDLE) ? r_sh :
                   (MSB_FIRST != 0)  ? (D << (LW'(W) - w_len_c)) : D;
    assign w_bit      = (MSB_FIRST != 0) ? w_src[W-1] : w_src[0];
    assign w_sh_nxt   = (MSB_FIRST != 0) ? (w_src << 1) : (w_src >> 1);
    assign w_lvl_nxt  = w_bit ? r_lvl : ~r_lvl;
    assign w_ones_nxt = w_bit ? (r_ones + OW'(1)) : '0;
    assign w_stuff    = (r_ones == OW'(STUFF_RUN));
    assign w_last     = (r_cnt == r_len);

    // Decide what the next bit period carries. The stuff check comes before
    // the end-of-payload check so a run ending on the last bit is still stuffed.
    always_comb begin
        w_emit     = 1'b0;
        w_to_stuff = 1'b0;
        w_to_eop   = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) begin
                    if (w_len_c == '0) w_to_eop = 1'b1;
                    else               w_emit   = 1'b1;
                end
            end
            SEND: begin
                if (w_stuff)     w_to_stuff = 1'b1;
                else if (w_last) w_to_eop   = 1'b1;
                else             w_emit     = 1'b1;
            end
            STUFF: begin
                if (w_last) w_to_eop = 1'b1;
                else        w_emit   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_sh     <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_ones   <= '0;
            r_lvl    <= 1'b1;
            ready    <= 1'b1;
            dp       <= 1'b1;
            dm       <= 1'b0;
            drive_en <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == IDLE && load) r_len <= w_len_c;

            if (w_emit) begin
                r_state  <= SEND;
                r_sh     <= w_sh_nxt;
                r_cnt    <= r_cnt + LW'(1);   // zero on entry from IDLE
                r_ones   <= w_ones_nxt;
                r_lvl    <= w_lvl_nxt;
                dp       <= w_lvl_nxt;
                dm       <= ~w_lvl_nxt;
                drive_en <= 1'b1;
                ready    <= 1'b0;
            end else if (w_to_stuff) begin
                // stuffed 0: toggle without consuming a payload bit
                r_state <= STUFF;
                r_ones  <= '0;
                r_lvl   <= ~r_lvl;
                dp      <= ~r_lvl;
                dm      <= r_lvl;
            end else if (w_to_eop) begin
                // counters and level are restored here so IDLE starts clean
                r_state  <= EOP0;
                r_cnt    <= '0;
                r_ones   <= '0;
                r_lvl    <= 1'b1;
                dp       <= 1'b0;
                dm       <= 1'b0;
                drive_en <= 1'b1;
                ready    <= 1'b0;
            end else begin
                case (r_state)
                    EOP0: r_state <= EOP1;
                    EOP1: begin
                        r_state <= EOPJ;
                        dp      <= 1'b1;
                        dm      <= 1'b0;
                        done    <= 1'b1;
                    end
                    EOPJ: begin
                        r_state  <= IDLE;
                        drive_en <= 1'b0;
                        ready    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
